// File: rtl/axi_pkg.sv
// Shared AXI constants and bridge state encoding for the icache read bridge.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/rd_beat_fifo.sv
// Two-deep beat buffer holding {data, last}; head entry is presented straight
// from the storage registers.
module rd_beat_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [32:0] push_data,
    input  logic        pop,
    output logic [32:0] head_data,
    output logic        full,
    output logic        empty
);

    logic [32:0] mem_q [2];
    logic [32:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        push_ok, pop_ok;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// Icache refill/uncached read bridge: one request -> one AXI4 INCR burst.
// Define ICACHE_AXI_RD_BEAT_CHECK_EN to frame bursts by beat count and flag rlast/rid errors.
//
// state | meaning
// IDLE  | ready for a cache request (r_rdy=1)
// AR    | presenting the burst on AR until arready
// R     | collecting R beats into the FIFO until the last beat is popped
module icache_axi_rd_bridge
    import axi_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r_req,
    input  logic [31:0]     r_addr,
    input  logic [7:0]      r_length,
    output logic            r_rdy,
    input  logic            r_data_ready,
    output logic            ret_valid,
    output logic            ret_last,
    output logic [31:0]     r_data,
    output logic            ret_err,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready
);

    bridge_state_e state_q, state_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [7:0]    arlen_q, arlen_d;
    logic          ret_err_q, ret_err_d;
    logic          push, pop, last_flag;
    logic          fifo_full, fifo_empty;
    logic [32:0]   head_data;

`ifdef ICACHE_AXI_RD_BEAT_CHECK_EN
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    assign last_flag = (beat_cnt_q == arlen_q);
`else
    logic          unused_rid;
    assign unused_rid = ^rid;
    assign last_flag  = rlast;
`endif

    assign pop = ret_valid && r_data_ready;

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        ret_err_d = ret_err_q;
        r_rdy     = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        push      = 1'b0;
`ifdef ICACHE_AXI_RD_BEAT_CHECK_EN
        beat_cnt_d = beat_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                r_rdy = 1'b1;
                if (r_req) begin
                    araddr_d  = r_addr;
                    arlen_d   = r_length;
                    ret_err_d = 1'b0;
`ifdef ICACHE_AXI_RD_BEAT_CHECK_EN
                    beat_cnt_d = 8'd0;
`endif
                    state_d   = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_d = R;
            end
            R: begin
                rready = !fifo_full;
                push   = rvalid && rready;
                if (push) begin
                    if (rresp != AXI_RESP_OKAY) ret_err_d = 1'b1;
`ifdef ICACHE_AXI_RD_BEAT_CHECK_EN
                    if (rlast != last_flag || rid != AXI_ID) ret_err_d = 1'b1;
                    beat_cnt_d = beat_cnt_q + 8'd1;
`endif
                end
                if (pop && ret_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            ret_err_q <= 1'b0;
`ifdef ICACHE_AXI_RD_BEAT_CHECK_EN
            beat_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            ret_err_q <= ret_err_d;
`ifdef ICACHE_AXI_RD_BEAT_CHECK_EN
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

    rd_beat_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({rdata, last_flag}),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ret_valid = !fifo_empty;
    assign r_data    = head_data[32:1];
    assign ret_last  = head_data[0];
    assign ret_err   = ret_err_q;
    assign arid      = AXI_ID;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arsize    = AXI_SIZE_4B;
    assign arburst   = AXI_BURST_INCR;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: refill, uncached, backpressure,
// AR stall, error response, reset mid-burst and (with the macro) early rlast.
module tb_icache_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_req;
    logic [31:0] r_addr;
    logic [7:0]  r_length;
    logic        r_rdy;
    logic        r_data_ready;
    logic        ret_valid, ret_last, ret_err;
    logic [31:0] r_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    icache_axi_rd_bridge #(.ID_W(4), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst), .r_req(r_req), .r_addr(r_addr), .r_length(r_length),
        .r_rdy(r_rdy), .r_data_ready(r_data_ready), .ret_valid(ret_valid),
        .ret_last(ret_last), .r_data(r_data), .ret_err(ret_err), .arid(arid),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the AR handshake.
    task automatic accept(input logic [31:0] addr, input logic [7:0] len, input int stall);
        chk("rrdy_idle", r_rdy, 1);
        r_req = 1'b1; r_addr = addr; r_length = len;
        @(negedge clk);
        r_req = 1'b0; r_addr = 32'hdead_beef; r_length = 8'hff;
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, addr);
        chk("arlen", arlen, len);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, 0);
        chk("rrdy_ar", r_rdy, 0);
        chk("err_clr", ret_err, 0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold", araddr, addr);
            chk("arlen_hold", arlen, len);
            chk("rrdy_stall", r_rdy, 0);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 0);
    endtask

    // Slave returns beats dbase+i; cache consumes with an optional stall window.
    task automatic run_beats(input int len, input logic [31:0] dbase, input int err_beat,
                             input int bp_start, input int bp_len, input int early,
                             input int stop_after, input logic exp_err);
        int cyc = 0, i = 0, nrx = 0;
        bit done = 0, hs = 0, saw_full = 0, err_pend = 0;
        while (!done && cyc < 300) begin
            if (err_pend) begin
                chk("err_set", ret_err, 1);
                err_pend = 0;
            end
            if (i <= len) begin
                rvalid = 1'b1;
                rdata  = dbase + 32'(i);
                rlast  = (i == len) || (i == early);
                rresp  = (i == err_beat) ? 2'b10 : 2'b00;
                rid    = 4'd0;
                hs     = rready;
                if (!rready) saw_full = 1;
            end else begin
                rvalid = 1'b0;
                hs     = 0;
            end
            r_data_ready = !(cyc >= bp_start && cyc < bp_start + bp_len);
            if (ret_valid && r_data_ready) begin
                chk("data", r_data, dbase + 32'(nrx));
                chk("last", ret_last, 32'(nrx == len));
                if (ret_last) done = 1;
                nrx++;
            end
            if (hs) begin
                if (i == err_beat) err_pend = 1;
                if (i == stop_after) done = 1;
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        rvalid = 1'b0;
        r_data_ready = 1'b0;
        chk("no_timeout", 32'(done), 1);
        if (stop_after < 0) begin
            chk("beats_rx", nrx, len + 1);
            chk("beats_tx", i, len + 1);
            chk("idle_after", r_rdy, 1);
            chk("empty_after", ret_valid, 0);
            chk("err_end", ret_err, exp_err);
            chk("rready_drop", 32'(saw_full), 32'(bp_len > 0));
        end
    endtask

    initial begin
        rst = 1'b1; r_req = 1'b0; r_addr = '0; r_length = '0; r_data_ready = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rrdy", r_rdy, 1);
        chk("rst_retv", ret_valid, 0);
        chk("rst_retl", ret_last, 0);
        chk("rst_arv", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_err", ret_err, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arsize", arsize, 3'b010);
        chk("rst_arburst", arburst, 2'b01);
        chk("rst_arid", arid, 0);
        rst = 1'b0;

        accept(32'h1c00_0040, 8'd15, 0);
        run_beats(15, 32'h0, -1, 0, 0, -1, -1, 1'b0);

        accept(32'h1fd0_0008, 8'd1, 0);
        run_beats(1, 32'ha5a5_0000, -1, 0, 0, -1, -1, 1'b0);

        accept(32'h1c00_0080, 8'd15, 0);
        run_beats(15, 32'h100, -1, 3, 5, -1, -1, 1'b0);

        accept(32'h1c00_00c0, 8'd15, 4);
        run_beats(15, 32'h200, -1, 0, 0, -1, -1, 1'b0);

        accept(32'h1c00_0000, 8'd15, 0);
        run_beats(15, 32'h300, 3, 0, 0, -1, -1, 1'b1);

        accept(32'h1fd0_0010, 8'd1, 0);
        run_beats(1, 32'h400, -1, 0, 0, -1, -1, 1'b0);

        accept(32'h1c00_0140, 8'd15, 0);
        run_beats(15, 32'h500, 2, 0, 0, -1, 5, 1'b1);
        chk("pre_rst_err", ret_err, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rrdy", r_rdy, 1);
        chk("mid_rst_retv", ret_valid, 0);
        chk("mid_rst_arv", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_err", ret_err, 0);
        chk("mid_rst_araddr", araddr, 0);
        rst = 1'b0;
        @(negedge clk);

        accept(32'h1fd0_0020, 8'd1, 0);
        run_beats(1, 32'h600, -1, 0, 0, -1, -1, 1'b0);

`ifdef ICACHE_AXI_RD_BEAT_CHECK_EN
        accept(32'h1c00_0180, 8'd15, 0);
        run_beats(15, 32'h700, -1, 0, 0, 10, -1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Memory-side responder for the instruction cache's refill/uncached read interface.
- Accepts one read request at a time on the cache-side handshake (r_req/r_rdy) and issues one AXI4 INCR burst on AR.
- Buffers R beats in a 2-entry FIFO and returns them as ret_valid/ret_last/r_data under the cache's r_data_ready.
- Sits between the icache and the AXI arbiter.

Parameters:
- AXI_ID, 4'd0, fixed ARID driven on every burst.
- ID_W, 4, ARID/RID width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- r_req  in  1  cache read request.
- r_addr  in  32  burst start address; cache supplies an aligned address.
- r_length  in  8  beats-1 in AXI encoding; 8'd15 = 16-beat line, 8'd1 = uncached 8 B.
- r_rdy  out  1  request accepted this cycle.
- r_data_ready  in  1  cache can take a beat this cycle.
- ret_valid  out  1  r_data holds a valid beat.
- ret_last  out  1  final beat of the burst.
- r_data  out  32  beat data.
- ret_err  out  1  sticky error flag, cleared on the next accepted request.
- arid  out  ID_W  AXI AR ID.
- araddr  out  32  AXI AR address.
- arlen  out  8  AXI AR burst length.
- arsize  out  3  AXI AR beat size.
- arburst  out  2  AXI AR burst type.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- rid  in  ID_W  AXI R ID.
- rdata  in  32  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, FIFO empty, ret_err=0.
  - r_rdy=1; ret_valid, ret_last, arvalid, rready all 0.
  - arid=AXI_ID, araddr=0, arlen=0, arsize=3'b010, arburst=2'b01.
  - Reset mid-burst abandons the burst; the outstanding AXI transaction is the interconnect's concern.
- FSM states: IDLE, AR, R.
  - IDLE: r_rdy = 1 (combinational, state only). r_req=1 latches r_addr/r_length into araddr/arlen, clears ret_err, moves to AR.
  - AR: arvalid=1 with latched values held stable. arvalid&arready moves to R. arvalid stays high until the handshake; no timeout.
  - R: rready = !fifo_full. Each rvalid&rready pushes {rdata, rlast}. Moves to IDLE on the cycle the entry with last=1 is popped (ret_valid & r_data_ready & ret_last).
- r_rdy is 0 in AR and R, so at most one outstanding burst.
- Latency, zero-wait AXI:
  - AR asserted 1 cycle after request acceptance.
  - First ret_valid 1 cycle after the first R handshake (registered FIFO output).
  - IDLE re-entered the cycle after the last pop, so back-to-back requests are spaced 1 cycle apart.
- FIFO: 2 entries, 1-bit pointers plus count.
  - Simultaneous push and pop when full is forbidden (rready=0 when full).
  - Simultaneous push and pop when count=1 keeps count=1.
  - Pop when empty is ignored.
  - ret_valid = count!=0; r_data/ret_last come from the head entry.
  - r_data_ready=0 with full FIFO stalls the AXI R channel indefinitely.
- rresp != 2'b00 on any accepted beat sets ret_err. The data is still forwarded and the burst completes normally.
- rid is ignored for function (single ID outstanding).

Optional Feature:
- Macro: ICACHE_AXI_RD_BEAT_CHECK_EN.
- With the macro defined:
  - An 8-bit beat counter resets to 0 on request acceptance and increments per R handshake.
  - Pushed last flag = (count==arlen); rlast is ignored for framing.
  - rlast mismatching (count==arlen) sets ret_err.
  - rid != AXI_ID sets ret_err.
- Without the macro: last flag = rlast, no counter, and rid is not checked.

Decomposition:
- Shared package (axi_pkg):
  - AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00.
  - Bridge state encoding {IDLE, AR, R}.
- One sub-module: rd_beat_fifo, a 2-deep, 33-bit-wide (data+last) synchronous FIFO with push/pop/full/empty.

Test Plan:
- Line refill: r_req, r_addr=32'h1c00_0040, r_length=15; AXI returns 16 beats rdata=i, rlast on 16th, arready=1 -> araddr=32'h1c00_0040, arlen=15, arsize=2, arburst=1; cache sees 16 ret_valid beats, data 0..15, ret_last only on beat 15; state back to IDLE one cycle after the last pop.
- Uncached read: r_length=1, r_addr=32'h1fd0_0008 -> arlen=1; 2 beats returned; ret_last on 2nd beat; ret_err=0.
- Backpressure: r_data_ready=0 for 5 cycles during a 16-beat burst -> rready drops once 2 entries are held; no beat lost or duplicated; order preserved.
- AR stall: arready=0 for 4 cycles -> arvalid held with araddr/arlen stable; r_rdy=0 throughout.
- Error response: beat 3 rresp=2'b10 -> ret_err=1 from the next cycle; all 16 beats still delivered; next request acceptance clears ret_err.
- Reset mid-burst: rst=1 after beat 5 -> next cycle r_rdy=1, ret_valid=0, FIFO empty, arvalid=0. With ICACHE_AXI_RD_BEAT_CHECK_EN, a separate run asserts rlast early on beat 10 of arlen=15 -> ret_err=1, and ret_last is still taken from the counter.
